// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - SRAM-like data responder with in-order latency queue
module data_sram_responder #(
    parameter int ADDRESS_WIDTH   = 10,
    parameter int BASE_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_ram_request,
    input  logic        data_ram_write,
    input  logic [1:0]  data_ram_size,
    input  logic [31:0] data_ram_address,
    input  logic [31:0] data_ram_write_data,
    input  logic [3:0]  data_ram_write_strobe,
    input  logic [1:0]  extra_delay,
    output logic        data_ram_address_ready,
    output logic        data_ram_data_ready,
    output logic [31:0] data_ram_read_data,
    output logic [2:0]  outstanding_count
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [31:0] mem [DEPTH];

    logic [31:0] data_q [MAX_OUTSTANDING];
    logic [2:0]  cnt_q  [MAX_OUTSTANDING];
    logic [31:0] data_n [MAX_OUTSTANDING];
    logic [2:0]  cnt_n  [MAX_OUTSTANDING];

    logic [2:0]  count_q, count_pop, count_n;
    logic        resp_q, resp_n;
    logic [31:0] rdata_q, rdata_n;

    logic                     accept, pop;
    logic [ADDRESS_WIDTH-1:0] word;
    logic [2:0]               load_cnt;
    logic [31:0]              entry_data;
    logic                     unused_bits;

    function automatic logic [2:0] dec_sat(input logic [2:0] c);
        return (c == 3'd0) ? 3'd0 : c - 3'd1;
    endfunction

    assign data_ram_address_ready = (count_q < 3'(MAX_OUTSTANDING));
    assign accept      = data_ram_request & data_ram_address_ready;
    // The head entry is the one being presented, so it leaves at the end of its response cycle.
    assign pop         = resp_q;
    assign word        = data_ram_address[ADDRESS_WIDTH+1:2];
    // Countdown holds the value seen the cycle after acceptance, hence the minus one.
    assign load_cnt    = 3'(BASE_LATENCY - 1) + {1'b0, extra_delay};
    assign entry_data  = data_ram_write ? 32'd0 : mem[word];
    assign unused_bits = ^{data_ram_size, data_ram_address[31:ADDRESS_WIDTH+2], data_ram_address[1:0]};

    always_ff @(posedge clock) begin
        if (accept && data_ram_write) begin
            for (int i = 0; i < 4; i++) begin
                if (data_ram_write_strobe[i]) begin
                    mem[word][8*i +: 8] <= data_ram_write_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            data_n[i] = data_q[i];
            cnt_n[i]  = dec_sat(cnt_q[i]);
        end
        if (pop) begin
            for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
                data_n[i] = data_q[i+1];
                cnt_n[i]  = dec_sat(cnt_q[i+1]);
            end
            data_n[MAX_OUTSTANDING-1] = 32'd0;
            cnt_n[MAX_OUTSTANDING-1]  = 3'd0;
        end
        count_pop = count_q - {2'b00, pop};
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (accept && (count_pop == 3'(i))) begin
                data_n[i] = entry_data;
                cnt_n[i]  = load_cnt;
            end
        end
        count_n = count_pop + {2'b00, accept};
        resp_n  = (count_n != 3'd0) && (cnt_n[0] == 3'd0);
        rdata_n = resp_n ? data_n[0] : 32'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 3'd0;
            resp_q  <= 1'b0;
            rdata_q <= 32'd0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                data_q[i] <= 32'd0;
                cnt_q[i]  <= 3'd0;
            end
        end else begin
            count_q <= count_n;
            resp_q  <= resp_n;
            rdata_q <= rdata_n;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                data_q[i] <= data_n[i];
                cnt_q[i]  <= cnt_n[i];
            end
        end
    end

    assign data_ram_data_ready = resp_q;
    assign data_ram_read_data  = rdata_q;
    assign outstanding_count   = count_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - directed self-checking bench for data_sram_responder
module tb_data_sram_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        request = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] address = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  strobe = 4'd0;
    logic [1:0]  extra = 2'd0;
    logic        ready;
    logic        resp;
    logic [31:0] rdata;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    data_sram_responder #(
        .ADDRESS_WIDTH(10),
        .BASE_LATENCY(1),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .data_ram_request(request),
        .data_ram_write(write),
        .data_ram_size(size),
        .data_ram_address(address),
        .data_ram_write_data(wdata),
        .data_ram_write_strobe(strobe),
        .extra_delay(extra),
        .data_ram_address_ready(ready),
        .data_ram_data_ready(resp),
        .data_ram_read_data(rdata),
        .outstanding_count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_resp, input logic [31:0] e_rdata,
                           input logic e_ready, input logic [2:0] e_count);
        chk({tag, ".data_ready"}, {31'd0, resp}, {31'd0, e_resp});
        chk({tag, ".read_data"}, rdata, e_rdata);
        chk({tag, ".address_ready"}, {31'd0, ready}, {31'd0, e_ready});
        chk({tag, ".count"}, {29'd0, count}, {29'd0, e_count});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] e);
        request = 1'b1;
        write   = w;
        address = a;
        wdata   = d;
        strobe  = s;
        extra   = e;
    endtask

    task automatic idle();
        request = 1'b0;
        write   = 1'b0;
    endtask

    initial begin
        #2;
        chk_out("reset", 1'b0, 32'd0, 1'b1, 3'd0);
        step();
        reset = 1'b1;

        // SW then LW, L=1
        drive(1'b1, 32'h100, 32'h12345678, 4'hF, 2'd0);
        step();
        chk_out("sw_resp", 1'b1, 32'd0, 1'b1, 3'd1);
        drive(1'b0, 32'h100, 32'd0, 4'h0, 2'd0);
        step();
        chk_out("lw_resp", 1'b1, 32'h12345678, 1'b1, 3'd1);
        idle();
        step();
        chk_out("idle1", 1'b0, 32'd0, 1'b1, 3'd0);

        // SB into lane 1, then null-strobe store, then LW
        drive(1'b1, 32'h101, 32'hABABABAB, 4'b0010, 2'd0);
        step();
        chk_out("sb_resp", 1'b1, 32'd0, 1'b1, 3'd1);
        drive(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 2'd0);
        step();
        chk_out("s0_resp", 1'b1, 32'd0, 1'b1, 3'd1);
        drive(1'b0, 32'h102, 32'd0, 4'h0, 2'd0);
        step();
        chk_out("lw_sb", 1'b1, 32'h1234AB78, 1'b1, 3'd1);

        // Alias: store at 0x104, load at 0x1000_0104
        drive(1'b1, 32'h104, 32'hCAFEF00D, 4'hF, 2'd0);
        step();
        chk_out("sw104", 1'b1, 32'd0, 1'b1, 3'd1);
        drive(1'b0, 32'h1000_0104, 32'd0, 4'h0, 2'd0);
        step();
        chk_out("lw_alias", 1'b1, 32'hCAFEF00D, 1'b1, 3'd1);
        idle();
        step();
        chk_out("idle2", 1'b0, 32'd0, 1'b1, 3'd0);

        // Three back-to-back loads, extra_delay=3 (L=4); c0 accept
        drive(1'b0, 32'h100, 32'd0, 4'h0, 2'd3);
        step();
        chk_out("q_c1", 1'b0, 32'd0, 1'b1, 3'd1);
        drive(1'b0, 32'h104, 32'd0, 4'h0, 2'd3);
        step();
        chk_out("q_c2", 1'b0, 32'd0, 1'b0, 3'd2);
        drive(1'b0, 32'h104, 32'd0, 4'h0, 2'd3);
        step();
        chk_out("q_c3", 1'b0, 32'd0, 1'b0, 3'd2);
        step();
        chk_out("q_c4", 1'b1, 32'h1234AB78, 1'b0, 3'd2);
        step();
        chk_out("q_c5", 1'b1, 32'hCAFEF00D, 1'b1, 3'd1);
        step();
        idle();
        chk_out("q_c6", 1'b0, 32'd0, 1'b1, 3'd1);
        step();
        chk_out("q_c7", 1'b0, 32'd0, 1'b1, 3'd1);
        step();
        chk_out("q_c8", 1'b0, 32'd0, 1'b1, 3'd1);
        step();
        chk_out("q_c9", 1'b1, 32'hCAFEF00D, 1'b1, 3'd1);
        step();
        chk_out("q_c10", 1'b0, 32'd0, 1'b1, 3'd0);

        // No overtaking: A extra 3 at c0, B extra 0 at c1
        drive(1'b0, 32'h100, 32'd0, 4'h0, 2'd3);
        step();
        drive(1'b0, 32'h104, 32'd0, 4'h0, 2'd0);
        step();
        idle();
        chk_out("ot_c2", 1'b0, 32'd0, 1'b0, 3'd2);
        step();
        chk_out("ot_c3", 1'b0, 32'd0, 1'b0, 3'd2);
        step();
        chk_out("ot_c4", 1'b1, 32'h1234AB78, 1'b0, 3'd2);
        step();
        chk_out("ot_c5", 1'b1, 32'hCAFEF00D, 1'b1, 3'd1);
        step();
        chk_out("ot_c6", 1'b0, 32'd0, 1'b1, 3'd0);

        // Reset with two queued entries
        drive(1'b0, 32'h100, 32'd0, 4'h0, 2'd3);
        step();
        drive(1'b0, 32'h104, 32'd0, 4'h0, 2'd3);
        step();
        idle();
        chk_out("pre_rst", 1'b0, 32'd0, 1'b0, 3'd2);
        reset = 1'b0;
        #1;
        chk_out("in_rst", 1'b0, 32'd0, 1'b1, 3'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("post_rst", 1'b0, 32'd0, 1'b1, 3'd0);
        end
        drive(1'b0, 32'h100, 32'd0, 4'h0, 2'd0);
        step();
        idle();
        chk_out("mem_kept", 1'b1, 32'h1234AB78, 1'b1, 3'd1);
        step();
        chk_out("final", 1'b0, 32'd0, 1'b1, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave/responder end of the core's SRAM-like data interface. Drives the initiator's data_ram_address_ready and returns read data.
- Accepts requests from the execute stage: request, write, size, address, write data and byte strobe.
- Holds an internal word-addressed memory. Returns one in-order response (data_ok plus read data) per accepted request after a configurable latency.
- Stands in for the data cache/bus bridge in core-level simulation and FPGA bring-up.

Parameters:
- ADDRESS_WIDTH, 10, word-index bits; memory depth is 2**ADDRESS_WIDTH 32-bit words.
- BASE_LATENCY, 1, minimum response latency in cycles; legal range 1..4.
- MAX_OUTSTANDING, 2, depth of the response queue; legal range 1..4.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_ram_request  input  1  initiator has a valid request.
- data_ram_write  input  1  1 = store, 0 = load.
- data_ram_size  input  2  00 byte, 01 half, 10 word; informational only.
- data_ram_address  input  32  byte address.
- data_ram_write_data  input  32  lane-replicated store data.
- data_ram_write_strobe  input  4  byte-lane enables for stores.
- extra_delay  input  2  additional latency for this request, sampled at acceptance.
- data_ram_address_ready  output  1  request accepted this cycle when high together with data_ram_request.
- data_ram_data_ready  output  1  one-cycle pulse per response (loads and stores).
- data_ram_read_data  output  32  load data, valid while data_ram_data_ready = 1.
- outstanding_count  output  3  current number of queued entries (debug).

Behaviour:
- Reset (reset = 0, asynchronous):
  - queue empty, outstanding_count = 0;
  - data_ram_data_ready = 0, data_ram_read_data = 0;
  - data_ram_address_ready = 1;
  - memory contents are not cleared.
- Reset asserted mid-operation discards all queued responses immediately; no pulse is issued for them.
- data_ram_address_ready = (outstanding_count < MAX_OUTSTANDING).
  - Depends only on registered state, never combinationally on data_ram_request.
  - No pop-bypass: when the queue is full, address_ready stays 0 in the cycle of a pop and rises the cycle after.
- Accept = data_ram_request & data_ram_address_ready, evaluated at the rising edge.
- Memory is indexed by word = data_ram_address[ADDRESS_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo depth.
- Store on accept:
  - byte lane i of the word is written with write_data[8i+7:8i] where write_strobe[i] = 1;
  - the write takes effect at the accept edge;
  - strobe 0000 writes nothing but still produces a response.
- Load on accept:
  - the full 32-bit word is captured into the queue entry at the accept edge;
  - a store accepted in cycle N is visible to a load accepted in cycle N+1 or later;
  - size and the low address bits do not alter the returned word; lane extraction is the initiator's job.
- Queue entry fields: read word (0 for stores) and a countdown loaded with L = BASE_LATENCY + extra_delay.
  - All entry countdowns decrement every cycle and saturate at 0.
- Response timing:
  - a request accepted in cycle A responds in cycle max(A + L, P + 1), where P is the response cycle of the previous request;
  - responses are strictly in order, at most one per cycle;
  - data_ram_data_ready and data_ram_read_data are registered outputs;
  - read_data = 0 on store responses and in all cycles without a response.
- Simultaneous accept and pop in the same cycle is legal; outstanding_count is unchanged.
- A shorter extra_delay on a younger request never overtakes an older request.
- Misaligned addresses are not checked; exceptions are detected upstream.

Test Plan:
- SW 0x12345678 @0x100, strobe 1111, then LW @0x100 with BASE_LATENCY=1 and extra_delay=0 -> each data_ok arrives 1 cycle after its accept; load returns 0x12345678.
- SB 0xAB to 0x101 (data 0xABABABAB, strobe 0010) over word 0x12345678, then LW -> 0x1234AB78.
- MAX_OUTSTANDING=2: three back-to-back loads, extra_delay=3 -> address_ready drops after the 2nd accept and rises the cycle after the first response; responses arrive in order, spaced ≥1 cycle.
- Load A with extra_delay=3, then load B with extra_delay=0 in the next cycle -> B responds exactly 1 cycle after A, never before.
- Address 0x1000_0104 with ADDRESS_WIDTH=10 -> aliases word 0x41 (same as 0x104); load returns the data previously stored at 0x104.
- Reset pulsed low with 2 entries queued -> data_ready drops immediately, no stale pulse, outstanding_count = 0; memory word at 0x100 still reads 0x1234AB78 afterwards.
